// File: rtl/packet_ejector.sv
// packet_ejector: NoC local-port receiver. Buffers flits per VC, reassembles
// header/body/tail into packets, returns credits and presents packets round-robin.
module packet_ejector #(
    parameter int V             = 4,
    parameter int B             = 4,
    parameter int Fpay          = 32,
    parameter int EAw           = 8,
    parameter int Cw            = 1,
    parameter int HDR_CLASS_LSB = 16,
    parameter int HDR_DATA_LSB  = 24,
    parameter int PCK_INJ_Dw    = 64,
    parameter int MAX_PCK_SIZ   = 16,
    parameter int PCK_SIZw      = $clog2(MAX_PCK_SIZ) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flit_wr_i,
    input  logic [2+V+Fpay-1:0]   flit_i,
    output logic [V-1:0]          credit_o,
    output logic                  pck_valid_o,
    input  logic                  pck_ready_i,
    output logic [PCK_INJ_Dw-1:0] pck_data_o,
    output logic [PCK_SIZw-1:0]   pck_size_o,
    output logic [EAw-1:0]        pck_src_e_addr_o,
    output logic [Cw-1:0]         pck_class_o,
    output logic [V-1:0]          pck_vc_o,
    output logic                  err_overflow_o,
    output logic                  err_protocol_o
);
    // state  | meaning
    // S_IDLE | waiting for a header at the FIFO head
    // S_BODY | header taken, collecting body flits until the tail
    // S_DONE | packet complete, waiting for grant; pops stalled (back-pressure)
    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DONE} state_t;

    localparam int HDw  = Fpay - HDR_DATA_LSB;
    localparam int Ew   = Fpay + 2;
    localparam int PTRw = (B > 1) ? $clog2(B) : 1;
    localparam int CNTw = $clog2(B + 1);
    localparam int VIw  = (V > 1) ? $clog2(V) : 1;

    state_t                state     [V];
    state_t                state_nxt [V];
    logic [Ew-1:0]         mem       [V][B];
    logic [PTRw-1:0]       wr_ptr    [V];
    logic [PTRw-1:0]       rd_ptr    [V];
    logic [CNTw-1:0]       count     [V];
    logic [PCK_INJ_Dw-1:0] data_q    [V];
    logic [PCK_INJ_Dw-1:0] data_nxt  [V];
    logic [PCK_SIZw-1:0]   size_q    [V];
    logic [PCK_SIZw-1:0]   size_nxt  [V];
    logic [EAw-1:0]        src_q     [V];
    logic [EAw-1:0]        src_nxt   [V];
    logic [Cw-1:0]         cls_q     [V];
    logic [Cw-1:0]         cls_nxt   [V];

    logic [V-1:0]    wr_en, pop, bad_seq, ovf;
    logic            flit_hdr, flit_tail, vc_onehot;
    logic [V-1:0]    flit_vc;
    logic [Fpay-1:0] flit_pay;
    logic            gnt_found, accept;
    logic [VIw-1:0]  gnt_idx, rr_ptr;

    function automatic logic [PTRw-1:0] ptr_inc(input logic [PTRw-1:0] p);
        return (p == PTRw'(B - 1)) ? '0 : p + 1'b1;
    endfunction

    assign {flit_hdr, flit_tail, flit_vc, flit_pay} = flit_i;
    assign vc_onehot = (flit_vc != '0) && ((flit_vc & (flit_vc - 1'b1)) == '0);

    always_comb begin
        wr_en = '0;
        ovf   = '0;
        for (int v = 0; v < V; v++) begin
            if (flit_wr_i && vc_onehot && flit_vc[v]) begin
                // full check uses the pre-pop occupancy
                if (count[v] == CNTw'(B)) ovf[v] = 1'b1;
                else                      wr_en[v] = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < V; i++) begin
            int j;
            j = (int'(rr_ptr) + i) % V;
            if (!gnt_found && state[j] == S_DONE) begin
                gnt_found = 1'b1;
                gnt_idx   = VIw'(j);
            end
        end
    end

    assign accept = gnt_found && pck_ready_i;

    always_comb begin
        pop     = '0;
        bad_seq = '0;
        for (int v = 0; v < V; v++) begin
            logic [Ew-1:0]         head;
            logic [PCK_INJ_Dw-1:0] mask;
            int                    off;
            head         = mem[v][rd_ptr[v]];
            off          = HDw + (int'(size_q[v]) - 1) * Fpay;
            mask         = PCK_INJ_Dw'({Fpay{1'b1}}) << off;
            state_nxt[v] = state[v];
            data_nxt[v]  = data_q[v];
            size_nxt[v]  = size_q[v];
            src_nxt[v]   = src_q[v];
            cls_nxt[v]   = cls_q[v];
            if (state[v] == S_DONE) begin
                if (accept && gnt_idx == VIw'(v)) state_nxt[v] = S_IDLE;
            end else if (count[v] != '0) begin
                pop[v] = 1'b1;
                if (head[Ew-1]) begin
                    bad_seq[v]   = (state[v] == S_BODY);
                    state_nxt[v] = head[Ew-2] ? S_DONE : S_BODY;
                    data_nxt[v]  = '0;
                    data_nxt[v][HDw-1:0] = head[Fpay-1:HDR_DATA_LSB];
                    size_nxt[v]  = PCK_SIZw'(1);
                    src_nxt[v]   = head[EAw-1:0];
                    cls_nxt[v]   = head[HDR_CLASS_LSB +: Cw];
                end else if (state[v] == S_IDLE) begin
                    bad_seq[v] = 1'b1;
                end else begin
                    // bits shifted past PCK_INJ_Dw fall off the top
                    data_nxt[v] = (data_q[v] & ~mask) |
                                  (PCK_INJ_Dw'(head[Fpay-1:0]) << off);
                    if (size_q[v] != PCK_SIZw'(MAX_PCK_SIZ)) size_nxt[v] = size_q[v] + 1'b1;
                    if (head[Ew-2]) state_nxt[v] = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < V; v++) begin
            if (wr_en[v]) mem[v][wr_ptr[v]] <= {flit_hdr, flit_tail, flit_pay};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                state[v]  <= S_IDLE;
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
                data_q[v] <= '0;
                size_q[v] <= '0;
                src_q[v]  <= '0;
                cls_q[v]  <= '0;
            end
            credit_o       <= '0;
            rr_ptr         <= '0;
            err_overflow_o <= 1'b0;
            err_protocol_o <= 1'b0;
        end else begin
            for (int v = 0; v < V; v++) begin
                state[v]  <= state_nxt[v];
                data_q[v] <= data_nxt[v];
                size_q[v] <= size_nxt[v];
                src_q[v]  <= src_nxt[v];
                cls_q[v]  <= cls_nxt[v];
                if (wr_en[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                if (pop[v])   rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                count[v] <= count[v] + CNTw'(wr_en[v]) - CNTw'(pop[v]);
            end
            credit_o <= pop;
            // parking the pointer on a stalled grant keeps it stable until accepted
            if (accept)         rr_ptr <= (gnt_idx == VIw'(V - 1)) ? '0 : gnt_idx + 1'b1;
            else if (gnt_found) rr_ptr <= gnt_idx;
            if (|ovf) err_overflow_o <= 1'b1;
            if ((|bad_seq) || (flit_wr_i && !vc_onehot)) err_protocol_o <= 1'b1;
        end
    end

    assign pck_valid_o      = gnt_found;
    assign pck_data_o       = gnt_found ? data_q[gnt_idx] : '0;
    assign pck_size_o       = gnt_found ? size_q[gnt_idx] : '0;
    assign pck_src_e_addr_o = gnt_found ? src_q[gnt_idx]  : '0;
    assign pck_class_o      = gnt_found ? cls_q[gnt_idx]  : '0;
    assign pck_vc_o         = gnt_found ? ({{(V-1){1'b0}}, 1'b1} << gnt_idx) : '0;

endmodule

// File: doc/packet_ejector.md
# packet_ejector

Endpoint-side receiver for the NoC local port. It accepts flits from the router's local output channel into per-VC flit FIFOs and returns one credit per consumed flit. It reassembles header, body and tail flits into whole packets and presents them on a valid/ready packet interface. It is the receive counterpart of the packet injector and shares its packet fields: data, size, class and source address.

## Interface
- V, 4: number of virtual channels.
- B, 4: per-VC flit FIFO depth. The router's credit counter for this port must initialise to B per VC.
- Fpay, 32: flit payload width.
- EAw, 8: endpoint address width. The source address sits at header payload [EAw-1:0].
- Cw, 1: message class width.
- HDR_CLASS_LSB, 16: LSB of the class field in the header payload.
- HDR_DATA_LSB, 24: LSB of the data carried in the header. HDw = Fpay-HDR_DATA_LSB (8 at defaults).
- PCK_INJ_Dw, 64: assembled data width.
- MAX_PCK_SIZ, 16: size saturation value. PCK_SIZw = log2(MAX_PCK_SIZ)+1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flit_wr_i  in  1  flit valid this cycle.
- flit_i  in  2+V+Fpay  flit, packed as {hdr_flag, tail_flag, vc[V-1:0] one-hot, payload}.
- credit_o  out  V  one-cycle credit pulse per VC.
- pck_valid_o  out  1  a complete packet is presented.
- pck_ready_i  in  1  the sink accepts the packet.
- pck_data_o  out  PCK_INJ_Dw  assembled data.
- pck_size_o  out  PCK_SIZw  packet length in flits.
- pck_src_e_addr_o  out  EAw  source endpoint address.
- pck_class_o  out  Cw  message class.
- pck_vc_o  out  V  one-hot VC of the presented packet.
- err_overflow_o  out  1  sticky: a flit arrived while its VC FIFO was full.
- err_protocol_o  out  1  sticky: an illegal flit sequence or illegal vc field was received.

## Operation
- **Input stage.** When flit_wr_i=1 and vc is one-hot, the flit is written into that VC's FIFO.
  - vc zero or multi-hot: flit dropped, err_protocol_o set, no credit returned.
  - Target FIFO full: flit dropped, err_overflow_o set.
- **Per-VC assembler states.** IDLE, BODY, DONE.
  - IDLE, FIFO non-empty, head is a header: pop it and latch src, class and header data into data[HDw-1:0]. Clear the remaining data bits and set size=1. If tail_flag is also set, go to DONE; otherwise go to BODY.
  - IDLE, head is not a header: pop and drop it, set err_protocol_o, return its credit.
  - BODY, head is a non-header: pop it. Body flit k (k≥1) writes data[HDw+(k-1)*Fpay +: Fpay]; bits at or above PCK_INJ_Dw are discarded. Increment size, saturating at MAX_PCK_SIZ. On a tail flit, go to DONE.
  - BODY, head is a header (tail missing): set err_protocol_o and restart assembly from this header with the IDLE rules, in the same cycle.
  - DONE: no pops. Flits stay in the FIFO, so no credit is returned and the router is back-pressured.
- **Credit return.** Every pop, including dropped flits, pulses credit_o[v] for one cycle.
- **Output arbitration.** Round-robin among VCs in DONE.
  - pck_valid_o=1 whenever any VC is in DONE. The outputs are driven combinationally from the granted VC's registers.
  - On pck_valid_o & pck_ready_i, the granted VC returns to IDLE and the pointer moves to the VC after the granted one.
  - While pck_ready_i=0, the grant and all packet outputs hold stable.

## Timing
- FIFO write occurs at the end of the flit_wr_i cycle t. The earliest pop of that flit is cycle t+1.
- credit_o is registered: a pop in cycle p gives credit_o pulse in p+1.
- Single-flit packet with flit_wr_i at t: pop at t+1, DONE at t+2, pck_valid_o at t+2, credit at t+2.
- N-flit back-to-back packet: the tail arrives at t+N-1 and pck_valid_o rises at t+N+1.
- Each VC pops at most one flit per cycle. Pops on different VCs are independent.
- A VC in DONE that is accepted at cycle a can pop its next header at a+1.
- Simultaneous FIFO write and pop on the same VC in the same cycle: legal. Occupancy is unchanged. A full FIFO that pops in the same cycle still rejects the write, because the full check uses the pre-pop count.
- Reset values: FIFOs empty, all VCs in IDLE, credit_o=0, pck_valid_o=0, pck_data_o=0, pck_size_o=0, pck_vc_o=0, errors=0, RR pointer at VC0.
- Reset mid-packet discards all partial and complete packets and returns no credits. The router must be reset in the same cycle.

## Test plan
- **Single flit.** Single flit on VC0 (hdr=tail=1, src=0x12, class=1, header data=0xAB) at t -> at t+2: pck_valid_o=1, size=1, data=0x00..AB, src=0x12, class=1, pck_vc_o=4'b0001; credit_o[0] pulses at t+2.
- **Three-flit packet.** VC1 packet: header data 0x5A, body 0x11223344, tail 0xCAFEBABE -> size=3, data=0x_FEBABE_11223344_5A (tail bits above 64 dropped), three credit pulses on VC1.
- **Back-pressure and overflow.** pck_ready_i=0 with a completed packet on VC2, then B+1 further flits on VC2 -> no credits after the DONE packet's pops, err_overflow_o=1 on the (B+1)th flit. Raising ready drains the FIFO and returns B credits.
- **Round robin.** VC0 and VC3 both in DONE with ready=1 -> VC0 is served, then VC3, then VC0 again after both reload.
- **Protocol errors.** Body flit on idle VC0, then header without tail followed by a new header -> err_protocol_o=1, the first packet is discarded, the second is delivered intact, and every flit is credited.
- **Reset mid-packet.** Reset asserted mid-packet on VC1 -> the next cycle shows all outputs at reset values, and the next packet assembles correctly.
